uart_mult_byte_tx: RTL
======================

UART_MULT_BYTE_TX -- requirements
Module: uart_mult_byte_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, gives the sys_clk frequency in Hz.
REQ-002 Parameter UART_BPS, default 115200, gives the line baud rate.
REQ-003 Port sys_clk, input, 1 bit, is the single clock; all logic is rising-edge.
REQ-004 Port sys_rst, input, 1 bit, is the asynchronous, active-high reset.
REQ-005 Port send_req, input, 1 bit, is a one-cycle request to transmit one packet.
REQ-006 Port dataA, input, 8 bits, is payload field A.
REQ-007 Port dataB, input, 16 bits, is payload field B.
REQ-008 Port dataC, input, 16 bits, is payload field C.
REQ-009 Port dataD, input, 8 bits, is payload field D.
REQ-010 Port uart_txd, output, 1 bit, is the serial line; it idles high.
REQ-011 Port busy, output, 1 bit, is high from request acceptance until packet end.
REQ-012 Port send_done, output, 1 bit, is a one-cycle pulse marking packet end.
REQ-013 Port byte_idx, output, 4 bits, is the index (0-8) of the byte currently on the line.

Function
REQ-014 BPS_CNT SHALL equal CLK_FREQ/UART_BPS (integer division); each bit lasts exactly BPS_CNT sys_clk cycles.
REQ-015 Each byte frame SHALL be 1 start bit (0), 8 data bits sent LSB first, then 1 stop bit (1).
REQ-016 The packet SHALL be 9 bytes in order: 0x55, 0xAA, dataA, dataB[15:8], dataB[7:0], dataC[15:8], dataC[7:0], dataD, CHK.
REQ-017 CHK SHALL be the low 8 bits of the sum of the six payload bytes; carries are discarded.
REQ-018 send_req SHALL be sampled only while busy=0; the module SHALL latch all fields and compute CHK in the acceptance cycle.
REQ-019 Field changes after acceptance SHALL NOT affect the packet in flight.
REQ-020 busy SHALL rise in the cycle after acceptance, and uart_txd SHALL fall to the start bit in that same cycle.
REQ-021 Bytes SHALL be sent back-to-back, with no idle gap between one stop bit and the next start bit.
REQ-022 The FSM SHALL have the states IDLE, LOAD, START, DATA, STOP, NEXT, and DONE.
REQ-023 The FSM transitions SHALL be:
- IDLE to LOAD on an accepted request;
- LOAD to START;
- START to DATA after BPS_CNT cycles;
- DATA to STOP after 8 bits;
- STOP to NEXT after BPS_CNT cycles;
- NEXT to START if byte_idx < 8, otherwise NEXT to DONE;
- DONE to IDLE.
LOAD and NEXT SHALL consume no line time, and the bit timer SHALL absorb them.
REQ-024 The start-bit edge to the end of the last stop bit SHALL be exactly 90*BPS_CNT cycles.
REQ-025 In the cycle after the last stop bit completes, send_done SHALL pulse high and busy SHALL fall.
REQ-026 A send_req coincident with send_done SHALL be accepted, giving a line gap of at most 1 cycle.
REQ-027 A send_req while busy=1 SHALL be ignored; it is not queued.
REQ-028 uart_txd SHALL be a registered output and SHALL be glitch-free.

Reset
REQ-029 On sys_rst assertion the module SHALL immediately set uart_txd=1, busy=0, send_done=0, byte_idx=0, and state=IDLE.
REQ-030 Reset in mid-packet SHALL abort the packet; no resumption and no send_done SHALL follow.
REQ-031 After sys_rst deasserts, the first request SHALL produce a complete, correct packet.

Structure
REQ-032 A shared package uart_pkg SHALL hold the header constants (0x55, 0xAA), PKT_LEN=9, and the FSM state encodings.
REQ-033 One sub-module, uart_byte_tx, SHALL serialize a single byte with a start/done handshake; uart_mult_byte_tx SHALL sequence bytes and compute CHK.

Verification
REQ-034 The bench SHALL use CLK_FREQ=1_000_000 and UART_BPS=100_000, giving BPS_CNT=10.
REQ-035 Basic packet:
- Stimulus: A=08, B=1234, C=ABCD, D=5A.
- Response: line bytes 55 AA 08 12 34 AB CD 5A 20.
- Response: send_done exactly 900 cycles after the start edge.
REQ-036 Bit timing: every bit SHALL sample correctly at mid-bit (cycle 5 of 10), and uart_txd SHALL be high before the start edge.
REQ-037 Busy rejection:
- Stimulus: a second send_req 200 cycles into a packet with other field values.
- Response: the first packet is unchanged.
- Response: no second packet and a single send_done.
REQ-038 Back-to-back:
- Stimulus: send_req held high on the send_done cycle.
- Response: the next start bit falls within 1 cycle.
- Response: the second packet is correct.
REQ-039 Checksum wrap: A=FF, B=FFFF, C=FFFF, D=FF SHALL give CHK=FA.
REQ-040 Mid-packet reset:
- Stimulus: sys_rst pulsed during byte 4.
- Response: uart_txd=1 and busy=0 immediately, with no send_done.
- Response: a new request sends a full correct packet.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and checksum helper for the multi-byte UART transmitter.
`timescale 1ns/1ps
package uart_pkg;

  // Packet framing constants
  localparam logic [7:0] HDR0       = 8'h55;
  localparam logic [7:0] HDR1       = 8'hAA;
  localparam int         PKT_LEN    = 9;
  localparam int         FRAME_BITS = 10;  // start + 8 data + stop

  // Packet sequencer states
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP,
    NEXT,
    DONE
  } state_t;

  // Checksum: low byte of the sum of the six payload bytes, carries dropped
  function automatic logic [7:0] calc_chk(input logic [7:0]  a,
                                          input logic [15:0] b,
                                          input logic [15:0] c,
                                          input logic [7:0]  d);
    logic [7:0] s;
    s = a + b[15:8] + b[7:0] + c[15:8] + c[7:0] + d;
    return s;
  endfunction

endpackage

// File: rtl/uart_mult_byte_tx_if.sv
// Request/payload and line/status signals of the multi-byte UART transmitter.
`timescale 1ns/1ps
interface uart_mult_byte_tx_if;

  logic        send_req;
  logic [7:0]  dataA;
  logic [15:0] dataB;
  logic [15:0] dataC;
  logic [7:0]  dataD;
  logic        uart_txd;
  logic        busy;
  logic        send_done;
  logic [3:0]  byte_idx;

  // Requester side
  modport master (
    output send_req, dataA, dataB, dataC, dataD,
    input  uart_txd, busy, send_done, byte_idx
  );

  // Transmitter side
  modport slave (
    input  send_req, dataA, dataB, dataC, dataD,
    output uart_txd, busy, send_done, byte_idx
  );

endinterface

// File: rtl/uart_byte_tx.sv
// Single-byte UART serializer: start bit, 8 data bits LSB first, stop bit.
// A start pulse may land on the final cycle of a stop bit so frames chain
// with no idle gap; done marks that final cycle.
`timescale 1ns/1ps
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int BPS_CNT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic [3:0] bit_no,
  output logic       bit_end,
  output logic       stop_pre_end,
  output logic       done
);

  localparam int              CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BPS_CNT - 2);
  localparam logic [3:0]       STOP_BIT = 4'(FRAME_BITS - 1);

  logic             active;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       frame;

  assign bit_end      = active && (cnt == CNT_LAST);
  assign done         = bit_end && (bit_no == STOP_BIT);
  assign stop_pre_end = active && (bit_no == STOP_BIT) && (cnt == CNT_PRE);

  // Capture the byte to shift out when a frame starts
  always_ff @(posedge clk) begin
    if (start) begin
      frame <= data;
    end
  end

  // Bit timer, bit position and registered line output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      txd    <= 1'b1;
      cnt    <= '0;
      bit_no <= '0;
    end else if (start) begin
      active <= 1'b1;
      txd    <= 1'b0;
      cnt    <= '0;
      bit_no <= '0;
    end else if (active) begin
      if (bit_end) begin
        cnt <= '0;
        if (bit_no == STOP_BIT) begin
          active <= 1'b0;
          txd    <= 1'b1;
        end else begin
          bit_no <= bit_no + 4'd1;
          txd    <= (bit_no == 4'd8) ? 1'b1 : frame[bit_no[2:0]];
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Nine-byte UART packet transmitter: 55 AA A B_hi B_lo C_hi C_lo D CHK.
// Payload is latched and the checksum computed in the acceptance cycle; the
// first start bit leaves on that same edge. LOAD is the first cycle of the
// first start bit and NEXT the last cycle of each stop bit, so neither adds
// line time. A request is accepted in IDLE or in DONE (the send_done cycle).
`timescale 1ns/1ps
module uart_mult_byte_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  uart_mult_byte_tx_if.slave  bus
);

  localparam int         BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam logic [3:0] LAST_IDX = 4'(PKT_LEN - 1);

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [7:0]  next_byte;
  logic        pkt_end;
  logic        busy;
  logic        send_done;
  logic [3:0]  byte_idx;

  logic        txd;
  logic [3:0]  bit_no;
  logic        bit_end;
  logic        stop_pre_end;
  logic        tx_done;

  logic [7:0]  a_q;
  logic [15:0] b_q;
  logic [15:0] c_q;
  logic [7:0]  d_q;
  logic [7:0]  chk_q;

  uart_byte_tx #(
    .BPS_CNT (BPS_CNT)
  ) u_byte_tx (
    .clk          (sys_clk),
    .rst          (sys_rst),
    .start        (tx_start),
    .data         (tx_data),
    .txd          (txd),
    .bit_no       (bit_no),
    .bit_end      (bit_end),
    .stop_pre_end (stop_pre_end),
    .done         (tx_done)
  );

  // Byte that follows the one currently on the line
  always_comb begin
    next_byte = 8'h00;
    case (byte_idx)
      4'd0:    next_byte = HDR1;
      4'd1:    next_byte = a_q;
      4'd2:    next_byte = b_q[15:8];
      4'd3:    next_byte = b_q[7:0];
      4'd4:    next_byte = c_q[15:8];
      4'd5:    next_byte = c_q[7:0];
      4'd6:    next_byte = d_q;
      4'd7:    next_byte = chk_q;
      default: next_byte = 8'h00;
    endcase
  end

  // Sequencer next state, request acceptance and byte launch
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    pkt_end    = 1'b0;
    tx_start   = 1'b0;
    tx_data    = next_byte;
    case (state)
      IDLE: begin
        if (bus.send_req) begin
          accept     = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD:  next_state = START;
      START: if (bit_end && (bit_no == 4'd0)) next_state = DATA;
      DATA:  if (bit_end && (bit_no == 4'd8)) next_state = STOP;
      STOP:  if (stop_pre_end)                next_state = NEXT;
      NEXT: begin
        if (tx_done) begin
          if (byte_idx < LAST_IDX) begin
            tx_start   = 1'b1;
            next_state = START;
          end else begin
            pkt_end    = 1'b1;
            next_state = DONE;
          end
        end
      end
      DONE: begin
        if (bus.send_req) begin
          accept     = 1'b1;
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (accept) begin
      tx_start = 1'b1;
      tx_data  = HDR0;
    end
  end

  // State register and status outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      send_done <= 1'b0;
      byte_idx  <= '0;
    end else begin
      state     <= next_state;
      send_done <= pkt_end;
      if (accept) begin
        busy     <= 1'b1;
        byte_idx <= '0;
      end else begin
        if (pkt_end) begin
          busy <= 1'b0;
        end
        if (tx_start) begin
          byte_idx <= byte_idx + 4'd1;
        end
      end
    end
  end

  // Latch the payload and its checksum on acceptance
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      a_q   <= bus.dataA;
      b_q   <= bus.dataB;
      c_q   <= bus.dataC;
      d_q   <= bus.dataD;
      chk_q <= calc_chk(bus.dataA, bus.dataB, bus.dataC, bus.dataD);
    end
  end

  assign bus.uart_txd  = txd;
  assign bus.busy      = busy;
  assign bus.send_done = send_done;
  assign bus.byte_idx  = byte_idx;

endmodule
